// File: rtl/fusion_retire_split.sv
// Splits a fused (ADD/ADDI/AUIPC + LOAD) commit entry into two ordered retirement
// records; non-fused entries pass through a single registered output stage.
module fusion_retire_split #(
  parameter int VLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             commit_valid_i,
  output logic             commit_ready_o,
  input  logic [VLEN-1:0]  commit_pc_i,
  input  logic [1:0]       commit_is_fusion_i,
  input  logic             commit_is_compressed_i,
  input  logic             commit_first_compressed_i,
  input  logic             commit_ex_valid_i,
  output logic             ret_valid_o,
  input  logic             ret_ready_i,
  output logic [VLEN-1:0]  ret_pc_o,
  output logic [VLEN-1:0]  ret_npc_o,
  output logic             ret_is_compressed_o,
  output logic             ret_fused_first_o,
  output logic             ret_ex_o,
  output logic [CNT_W-1:0] fused_count_o
);

  // state  | meaning
  // IDLE   | output stage empty or holding a plain/second record; commits accepted
  // SECOND | first half of a pair is on the output; second half latched, waiting
  typedef enum logic {IDLE, SECOND} state_e;

  state_e            state_q, state_d;
  logic              ret_valid_q, ret_valid_d;
  logic [VLEN-1:0]   ret_pc_q, ret_pc_d;
  logic [VLEN-1:0]   ret_npc_q, ret_npc_d;
  logic              ret_comp_q, ret_comp_d;
  logic              ret_ff_q, ret_ff_d;
  logic              ret_ex_q, ret_ex_d;
  logic              ret_second_q, ret_second_d;
  logic [VLEN-1:0]   pc2_q, pc2_d;
  logic              s2_comp_q, s2_comp_d;
  logic              ex2_q, ex2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic out_fire, accept, s1_comp, s2_comp, is_fused;

  function automatic logic [VLEN-1:0] isize(input logic comp);
    return comp ? VLEN'(2) : VLEN'(4);
  endfunction

  // Gated by rst_ni so the port reads 0 while reset is asserted.
  assign commit_ready_o = rst_ni && (state_q == IDLE) && (!ret_valid_q || ret_ready_i) && !flush_i;
  assign out_fire       = ret_valid_q && ret_ready_i;
  assign accept         = commit_valid_i && commit_ready_o;
  assign is_fused       = (commit_is_fusion_i != 2'b00);
  assign s1_comp        = (commit_is_fusion_i == 2'b01) ||
                          ((commit_is_fusion_i == 2'b10) && commit_first_compressed_i);
  assign s2_comp        = (commit_is_fusion_i == 2'b10) ? !s1_comp : s1_comp;

  always_comb begin
    state_d      = state_q;
    ret_valid_d  = ret_valid_q;
    ret_pc_d     = ret_pc_q;
    ret_npc_d    = ret_npc_q;
    ret_comp_d   = ret_comp_q;
    ret_ff_d     = ret_ff_q;
    ret_ex_d     = ret_ex_q;
    ret_second_d = ret_second_q;
    pc2_d        = pc2_q;
    s2_comp_d    = s2_comp_q;
    ex2_d        = ex2_q;
    cnt_d        = cnt_q;
    if (flush_i) begin
      ret_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      if (out_fire && ret_second_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q == SECOND) begin
        if (out_fire) begin
          ret_valid_d  = 1'b1;
          ret_pc_d     = pc2_q;
          ret_npc_d    = pc2_q + isize(s2_comp_q);
          ret_comp_d   = s2_comp_q;
          ret_ff_d     = 1'b0;
          ret_ex_d     = ex2_q;
          ret_second_d = 1'b1;
          state_d      = IDLE;
        end
      end else if (accept) begin
        ret_valid_d  = 1'b1;
        ret_pc_d     = commit_pc_i;
        ret_second_d = 1'b0;
        if (!is_fused) begin
          ret_npc_d  = commit_pc_i + isize(commit_is_compressed_i);
          ret_comp_d = commit_is_compressed_i;
          ret_ff_d   = 1'b0;
          ret_ex_d   = commit_ex_valid_i;
        end else begin
          // The exception belongs to the load, so it rides on the second record.
          ret_npc_d  = commit_pc_i + isize(s1_comp);
          ret_comp_d = s1_comp;
          ret_ff_d   = 1'b1;
          ret_ex_d   = 1'b0;
          pc2_d      = commit_pc_i + isize(s1_comp);
          s2_comp_d  = s2_comp;
          ex2_d      = commit_ex_valid_i;
          state_d    = SECOND;
        end
      end else if (out_fire) begin
        ret_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ret_valid_q  <= 1'b0;
      ret_pc_q     <= '0;
      ret_npc_q    <= '0;
      ret_comp_q   <= 1'b0;
      ret_ff_q     <= 1'b0;
      ret_ex_q     <= 1'b0;
      ret_second_q <= 1'b0;
      pc2_q        <= '0;
      s2_comp_q    <= 1'b0;
      ex2_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ret_valid_q  <= ret_valid_d;
      ret_pc_q     <= ret_pc_d;
      ret_npc_q    <= ret_npc_d;
      ret_comp_q   <= ret_comp_d;
      ret_ff_q     <= ret_ff_d;
      ret_ex_q     <= ret_ex_d;
      ret_second_q <= ret_second_d;
      pc2_q        <= pc2_d;
      s2_comp_q    <= s2_comp_d;
      ex2_q        <= ex2_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ret_valid_o         = ret_valid_q;
  assign ret_pc_o            = ret_pc_q;
  assign ret_npc_o           = ret_npc_q;
  assign ret_is_compressed_o = ret_comp_q;
  assign ret_fused_first_o   = ret_ff_q;
  assign ret_ex_o            = ret_ex_q;
  assign fused_count_o       = cnt_q;

endmodule
